// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART byte buffer and its producer/consumer.
// slave = the buffer itself; master = the side that writes bytes and consumes the head.
interface uart_rx_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  logic                       in_valid;
  logic [WIDTH-1:0]           in_data;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_data;
  logic                       out_ready;
  logic [$clog2(DEPTH):0]     count;
  logic                       full;
  logic                       empty;
  logic                       overflow;
  logic                       overflow_clear;

  modport slave (
    input  in_valid, in_data, out_ready, overflow_clear,
    output out_valid, out_data, count, full, empty, overflow
  );

  modport master (
    output in_valid, in_data, out_ready, overflow_clear,
    input  out_valid, out_data, count, full, empty, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind uart_rx; a byte written at edge N is visible after edge N.
// Backpressure: the consumer stalls via out_ready; bytes arriving while full without a pop are dropped and flagged in sticky overflow.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic             full_q;
  logic             empty_q;
  logic             overflow_q;
  logic             push;
  logic             pop;
  logic             drop;

  assign pop  = !empty_q && bus.out_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign push = bus.in_valid && (!full_q || pop);
  assign drop = bus.in_valid && full_q && !pop;

  always_comb begin
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + CW'(1);
    end else if (pop && !push) begin
      count_next = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_next;
      full_q  <= (count_next == FULL_CNT);
      empty_q <= (count_next == '0);
      // A fresh drop outranks a clear in the same cycle.
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (bus.overflow_clear) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  assign bus.out_valid = !empty_q;
  assign bus.out_data  = empty_q ? '0 : mem[rd_ptr];
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (WIDTH=8, DEPTH=16).
module tb_uart_rx_fifo;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  uart_rx_fifo_if #(.WIDTH(8), .DEPTH(16)) bus ();

  uart_rx_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; outputs are observed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid       = 1'b0;
    bus.in_data        = 8'h00;
    bus.out_ready      = 1'b0;
    bus.overflow_clear = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    vectors++;
    if (bus.empty !== 1'b1) begin
      miscompares++; $display("FAIL reset_empty got %b exp 1", bus.empty);
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
    end
    vectors++;
    if (bus.count !== 5'd0) begin
      miscompares++; $display("FAIL reset_count got %0d exp 0", bus.count);
    end
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++; $display("FAIL reset_overflow got %b exp 0", bus.overflow);
    end
    vectors++;
    if (bus.out_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_out_data got %h exp 00", bus.out_data);
    end
    vectors++;
    if (bus.full !== 1'b0) begin
      miscompares++; $display("FAIL reset_full got %b exp 0", bus.full);
    end
  endtask

  task automatic test_single();
    bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
      miscompares++; $display("FAIL single_head got v=%b d=%h exp v=1 d=a5", bus.out_valid, bus.out_data);
    end
    vectors++;
    if (bus.count !== 5'd1) begin
      miscompares++; $display("FAIL single_count got %0d exp 1", bus.count);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.empty !== 1'b1 || bus.count !== 5'd0 || bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_pop got e=%b c=%0d v=%b exp e=1 c=0 v=0", bus.empty, bus.count, bus.out_valid);
    end
    // Empty with write and ready together: no bypass, nothing popped.
    bus.in_valid = 1'b1; bus.in_data = 8'h7E; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    vectors++;
    if (bus.count !== 5'd1 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h7E) begin
      miscompares++; $display("FAIL empty_push_ready got c=%0d v=%b d=%h exp c=1 v=1 d=7e", bus.count, bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.empty !== 1'b1) begin
      miscompares++; $display("FAIL empty_push_ready_drain got e=%b exp 1", bus.empty);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(i);
      tick();
    end
    vectors++;
    if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
      miscompares++; $display("FAIL ovf_fill got f=%b c=%0d exp f=1 c=16", bus.full, bus.count);
    end
    bus.in_data = 8'hFF;
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
      miscompares++; $display("FAIL ovf_drop got o=%b c=%0d exp o=1 c=16", bus.overflow, bus.count);
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i)) begin
        miscompares++; $display("FAIL ovf_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.out_valid, bus.out_data, 8'(i));
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    vectors++;
    if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_after_drain got e=%b o=%b exp e=1 o=1", bus.empty, bus.overflow);
    end
    bus.overflow_clear = 1'b1;
    tick();
    bus.overflow_clear = 1'b0;
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++; $display("FAIL ovf_clear got %b exp 0", bus.overflow);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'h20 + 8'(i);
      tick();
    end
    bus.in_data = 8'h55; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    vectors++;
    if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
      miscompares++; $display("FAIL fullpp_state got c=%0d f=%b o=%b exp c=16 f=1 o=0", bus.count, bus.full, bus.overflow);
    end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      exp_d = (i == 15) ? 8'h55 : 8'h21 + 8'(i);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) begin
        miscompares++; $display("FAIL fullpp_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, bus.out_valid, bus.out_data, exp_d);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    vectors++;
    if (bus.empty !== 1'b1) begin
      miscompares++; $display("FAIL fullpp_empty got %b exp 1", bus.empty);
    end
  endtask

  task automatic test_wrap();
    int max_cnt;
    max_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'h10 + 8'(i);
      tick();
      bus.in_valid = 1'b0;
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      vectors++;
      if (bus.out_data !== 8'h10 + 8'(i)) begin
        miscompares++; $display("FAIL wrap[%0d] got %h exp %h", i, bus.out_data, 8'h10 + 8'(i));
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    end
    vectors++;
    if (max_cnt !== 1 || bus.empty !== 1'b1) begin
      miscompares++; $display("FAIL wrap_count got max=%0d e=%b exp max=1 e=1", max_cnt, bus.empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'h80 + 8'(i);
      tick();
    end
    bus.in_data = 8'h99; reset = 1'b1;
    tick();
    reset = 1'b0; bus.in_valid = 1'b0;
    vectors++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      miscompares++; $display("FAIL midreset got c=%0d e=%b v=%b d=%h exp c=0 e=1 v=0 d=00", bus.count, bus.empty, bus.out_valid, bus.out_data);
    end
    bus.in_valid = 1'b1; bus.in_data = 8'h3C;
    tick();
    vectors++;
    if (bus.out_data !== 8'h3C || bus.count !== 5'd1) begin
      miscompares++; $display("FAIL midreset_push got d=%h c=%0d exp d=3c c=1", bus.out_data, bus.count);
    end
    for (int i = 0; i < 15; i++) begin
      bus.in_data = 8'hC0 + 8'(i);
      tick();
    end
    bus.in_data = 8'hEE; bus.overflow_clear = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
      miscompares++; $display("FAIL clear_vs_drop got o=%b c=%0d exp o=1 c=16", bus.overflow, bus.count);
    end
    tick();
    bus.overflow_clear = 1'b0;
    vectors++;
    if (bus.overflow !== 1'b0 || bus.out_data !== 8'h3C) begin
      miscompares++; $display("FAIL clear_after got o=%b d=%h exp o=0 d=3c", bus.overflow, bus.out_data);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Byte buffer directly downstream of uart_rx. It absorbs each received byte on uart_rx's single-cycle ready strobe.
- It presents the bytes in order to a consumer (display logic, CPU I/O port) through a valid/ready handshake.
- It decouples bursty 115200-baud arrivals from a consumer that may stall, and flags bytes lost to overflow.

Parameters:
- WIDTH, 8, data width in bits; matches the uart_rx data output.
- DEPTH, 16, number of entries; must be a power of 2, minimum 2.

Ports:
- clk  input  1  system clock; same clock as uart_rx.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  write strobe; wired to uart_rx ready; one cycle per byte.
- in_data  input  WIDTH  byte to write; sampled only when in_valid=1.
- out_valid  output  1  head entry available on out_data.
- out_data  output  WIDTH  head entry (first-word-fall-through).
- out_ready  input  1  consumer accepts the head this cycle.
- count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky; a byte was dropped.
- overflow_clear  input  1  clears overflow.

Behaviour:
- Reset, synchronous and active-high, sampled on the clk rising edge. Outcome: rd_ptr=wr_ptr=0, count=0, out_valid=0, empty=1, full=0, overflow=0, out_data=0. Reset overrides every other input in the same cycle.
- Storage: DEPTH x WIDTH register array. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- push = in_valid && (!full || pop).
- pop = out_valid && out_ready. pop is ignored when empty, and never underflows.
- On push: mem[wr_ptr] <= in_data; wr_ptr++.
- On pop: rd_ptr++.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- out_valid = !empty, registered via count. out_data = mem[rd_ptr], stable while out_valid && !out_ready.
- Latency: a byte written into an empty FIFO at edge N appears with out_valid=1 after edge N. That is one cycle after in_valid; there is no same-cycle bypass.
- Empty with in_valid and out_ready: the byte is written, nothing is popped, and out_valid rises next cycle.
- Full with in_valid and pop in the same cycle: both happen. count stays DEPTH and no data is lost.
- Full with in_valid and no pop: the byte is dropped, the FIFO contents are unchanged, and overflow <= 1.
- overflow is sticky until overflow_clear=1. If overflow_clear and a new drop occur in the same cycle, set wins (overflow stays 1).
- full and empty are registered and consistent with count in the same cycle.
- A pointer wrap-around is invisible to the consumer; ordering is strictly FIFO.
- Reset mid-operation: contents are discarded and any in-flight in_valid in the reset cycle is ignored. Mem array contents need no reset, but out_data reads 0 when empty after reset.
- Top-level hookup: in_valid=rx.ready, in_data=rx.data. The display consumes with out_ready=1.

Test Plan:
- Reset, then idle 10 cycles -> empty=1, out_valid=0, count=0, overflow=0, out_data=8'h00.
- Push 8'hA5 with out_ready=0 -> next cycle out_valid=1, out_data=8'hA5, count=1. Assert out_ready for 1 cycle -> empty=1, count=0.
- Push 8'h00..8'h0F (16 bytes, DEPTH=16) with out_ready=0 -> full=1, count=16. Push 8'hFF -> overflow=1, count=16. Drain 16 -> reads 8'h00..8'h0F in order and 8'hFF is never seen. Pulse overflow_clear -> overflow=0.
- Full FIFO, in_valid=1 with 8'h55 and out_ready=1 in the same cycle -> count stays 16, overflow stays 0. After the full drain, the last byte read is 8'h55.
- Wrap: alternate push/pop of 40 bytes 8'h10..8'h37 -> output sequence identical to input, count never exceeds 1, pointers wrap twice.
- Fill 5 bytes, assert reset mid-stream with in_valid=1 -> next cycle count=0, empty=1, out_valid=0. A subsequent push of 8'h3C reads back 8'h3C first. overflow_clear and a drop in the same cycle -> overflow=1.
